// File: rtl/id_symbol_shower.sv
// Calibration LED driver: shows one address symbol per slot as a palette colour, with manual or auto slot advance.
// Optional parity slot enabled by defining PARITY_SYMBOL_EN.
module id_symbol_shower #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 6,
  parameter int BITS_PER_SYMBOL   = 1,
  parameter int FRAMES_PER_SYMBOL = 4,
  localparam int NUM_SYMBOLS = (LED_ADDRESS_WIDTH + BITS_PER_SYMBOL - 1) / BITS_PER_SYMBOL,
  localparam int SLOT_W      = $clog2(NUM_SYMBOLS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
  input  logic                         auto_mode,
  input  logic                         update_slot,
  input  logic [SLOT_W-1:0]            slot_req,
  output logic [7:0]                   red_out,
  output logic [7:0]                   green_out,
  output logic [7:0]                   blue_out,
  output logic                         color_valid,
  output logic                         displayed_frame_valid,
  output logic [SLOT_W-1:0]            current_slot,
  output logic                         sequence_done
);

`ifdef PARITY_SYMBOL_EN
  localparam int NUM_SLOTS = NUM_SYMBOLS + 1;
`else
  localparam int NUM_SLOTS = NUM_SYMBOLS;
`endif
  localparam int PAD_W = NUM_SYMBOLS * BITS_PER_SYMBOL;
  localparam int CNT_W = $clog2(FRAMES_PER_SYMBOL + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FRAMES_PER_SYMBOL);

  typedef enum logic [1:0] {
    SETTLE0 = 2'd0,
    SETTLE1 = 2'd1,
    VALID   = 2'd2
  } state_t;

  generate
    if ((BITS_PER_SYMBOL != 1 && BITS_PER_SYMBOL != 2) || FRAMES_PER_SYMBOL < 1 ||
        NUM_LEDS > (1 << LED_ADDRESS_WIDTH)) begin : g_bad_cfg
      $error("id_symbol_shower: illegal parameter combination");
    end
  endgenerate

`ifdef PARITY_SYMBOL_EN
  function automatic logic [BITS_PER_SYMBOL-1:0] f_parity(input logic [PAD_W-1:0] padded);
    logic [BITS_PER_SYMBOL-1:0] acc;
    acc = {BITS_PER_SYMBOL{1'b0}};
    for (int s = 0; s < NUM_SYMBOLS; s++) begin
      acc = acc ^ padded[s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL];
    end
    return acc;
  endfunction
`endif

  // Slot 0 is the most significant symbol; any slot past the data symbols is the parity slot.
  function automatic logic [BITS_PER_SYMBOL-1:0] f_symbol(input logic [PAD_W-1:0] padded,
                                                          input logic [SLOT_W-1:0] slot);
    logic [BITS_PER_SYMBOL-1:0] sym;
`ifdef PARITY_SYMBOL_EN
    sym = f_parity(padded);
`else
    sym = {BITS_PER_SYMBOL{1'b0}};
`endif
    for (int s = 0; s < NUM_SYMBOLS; s++) begin
      if (slot == SLOT_W'(s)) begin
        sym = padded[(NUM_SYMBOLS-1-s)*BITS_PER_SYMBOL +: BITS_PER_SYMBOL];
      end
    end
    return sym;
  endfunction

  function automatic logic [23:0] f_palette(input logic [BITS_PER_SYMBOL-1:0] sym);
    logic [1:0]  idx;
    logic [23:0] rgb;
    if (BITS_PER_SYMBOL == 1) begin
      idx = {sym[0], 1'b0};
    end else begin
      idx = 2'(sym);
    end
    case (idx)
      2'd0:    rgb = 24'hFF0000;
      2'd1:    rgb = 24'h00FF00;
      2'd2:    rgb = 24'h0000FF;
      2'd3:    rgb = 24'hFFFFFF;
      default: rgb = 24'hFF0000;
    endcase
    return rgb;
  endfunction

  logic [PAD_W-1:0]             w_padded;
  logic                         w_frame_start;
  logic [LED_ADDRESS_WIDTH-1:0] r_prev;
  logic [CNT_W-1:0]             r_count;
  state_t                       r_state;

  assign w_padded              = PAD_W'(next_led_request);
  assign w_frame_start         = (next_led_request != r_prev) &&
                                 (r_prev == {LED_ADDRESS_WIDTH{1'b0}});
  assign displayed_frame_valid = (r_state == VALID);

  // Colour pipeline, frame tracking FSM and slot sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_out       <= 8'd0;
      green_out     <= 8'd0;
      blue_out      <= 8'd0;
      color_valid   <= 1'b0;
      current_slot  <= {SLOT_W{1'b0}};
      sequence_done <= 1'b0;
      r_prev        <= {LED_ADDRESS_WIDTH{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      r_state       <= SETTLE0;
    end else begin
      {red_out, green_out, blue_out} <= f_palette(f_symbol(w_padded, current_slot));
      color_valid   <= 1'b1;
      r_prev        <= next_led_request;
      sequence_done <= 1'b0;
      if (update_slot) begin
        current_slot <= (int'(slot_req) < NUM_SLOTS) ? slot_req : LAST_SLOT;
        r_state      <= SETTLE0;
        r_count      <= {CNT_W{1'b0}};
      end else if (w_frame_start) begin
        case (r_state)
          SETTLE0: r_state <= SETTLE1;
          SETTLE1: r_state <= VALID;
          VALID: begin
            if (auto_mode && r_count == CNT_MAX) begin
              if (current_slot == LAST_SLOT) begin
                current_slot  <= {SLOT_W{1'b0}};
                sequence_done <= 1'b1;
              end else begin
                current_slot <= current_slot + SLOT_W'(1);
              end
              r_state <= SETTLE0;
              r_count <= {CNT_W{1'b0}};
            end else if (r_count != CNT_MAX) begin
              r_count <= r_count + CNT_W'(1);
            end else begin
              r_count <= r_count;
            end
          end
          default: r_state <= SETTLE0;
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

endmodule

// File: tb/tb_id_symbol_shower.sv
// Randomised scoreboard bench for id_symbol_shower in its default configuration.
module tb_id_symbol_shower;
  localparam int NSYM  = 6;
  localparam int NSLOT = 6;
  localparam int FPS   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] next_led_request = 6'd0;
  logic       auto_mode = 1'b0;
  logic       update_slot = 1'b0;
  logic [2:0] slot_req = 3'd0;
  logic [7:0] red_out, green_out, blue_out;
  logic       color_valid, displayed_frame_valid, sequence_done;
  logic [2:0] current_slot;

  always #5 clk = ~clk;

  id_symbol_shower dut (
    .clk(clk), .rst_n(rst_n), .next_led_request(next_led_request),
    .auto_mode(auto_mode), .update_slot(update_slot), .slot_req(slot_req),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .color_valid(color_valid), .displayed_frame_valid(displayed_frame_valid),
    .current_slot(current_slot), .sequence_done(sequence_done)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        cv;
    logic        dfv;
    logic [2:0]  slot;
    logic        sd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_slot = 0;
  int m_fs = 0;     // frame starts seen since the current slot was entered
  int m_prev = 0;
  int m_wraps = 0;
  int dut_pulses = 0;
  bit want_hit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_colour(input int req, input int slot);
    int bitv;
    bitv = (req >> (NSYM - 1 - slot)) & 1;
    return (bitv != 0) ? 24'h0000FF : 24'hFF0000;
  endfunction

  task automatic step(input logic rst, input int req, input logic am, input logic upd, input int sreq);
    exp_t e;
    bit   fs;
    @(negedge clk);
    rst_n            = rst;
    next_led_request = req[5:0];
    auto_mode        = am;
    update_slot      = upd;
    slot_req         = sreq[2:0];
    if (!rst) begin
      m_slot = 0; m_fs = 0; m_prev = 0;
      e = '0;
    end else begin
      e.rgb = ref_colour(req, m_slot);
      e.cv  = 1'b1;
      e.sd  = 1'b0;
      fs = (req != m_prev) && (m_prev == 0);
      m_prev = req;
      if (upd) begin
        m_slot = (sreq < NSLOT) ? sreq : NSLOT - 1;
        m_fs = 0;
      end else if (fs) begin
        if (am && m_fs >= FPS + 2) begin
          if (m_slot == NSLOT - 1) begin
            e.sd = 1'b1;
            m_wraps++;
          end
          m_slot = (m_slot + 1) % NSLOT;
          m_fs = 0;
        end else begin
          m_fs++;
        end
      end
      e.dfv  = (m_fs >= 2);
      e.slot = m_slot[2:0];
    end
    q.push_back(e);
  endtask

  task automatic sweep(input logic am, input int n);
    logic upd;
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < 50; r++) begin
        upd = 1'b0;
        if (want_hit && am && m_prev == 0 && r != 0 && m_fs >= FPS + 2) begin
          upd = 1'b1;
          want_hit = 1'b0;
        end
        step(1'b1, r, am, upd, 2);
      end
    end
  endtask

  // Scoreboard monitor: one expectation per clock while outputs are presented.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("colour", {8'd0, red_out, green_out, blue_out}, {8'd0, e.rgb});
      check("color_valid", {31'd0, color_valid}, {31'd0, e.cv});
      check("frame_valid", {31'd0, displayed_frame_valid}, {31'd0, e.dfv});
      check("current_slot", {29'd0, current_slot}, {29'd0, e.slot});
      check("sequence_done", {31'd0, sequence_done}, {31'd0, e.sd});
      if (sequence_done === 1'b1) dut_pulses++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic am;
    logic upd;
    logic rst;
    int   req;
    int   sreq;
    // Reset held with an active request and update strobe.
    for (int i = 0; i < 3; i++) step(1'b0, 37, 1'b0, 1'b1, 0);
    // Manual slot 0: MSB of 32 is 1 (blue), of 5 is 0 (red).
    step(1'b1, 32, 1'b0, 1'b1, 0);
    step(1'b1, 32, 1'b0, 1'b0, 0);
    step(1'b1, 5, 1'b0, 1'b0, 0);
    // Clamp of out-of-range slot request, then frame tracking in manual mode.
    step(1'b1, 0, 1'b0, 1'b1, 7);
    step(1'b1, 0, 1'b0, 1'b1, 3);
    sweep(1'b0, 4);
    // Auto mode through at least one full wrap, then an update coinciding with an advance.
    step(1'b1, 0, 1'b0, 1'b1, 0);
    sweep(1'b1, 45);
    want_hit = 1'b1;
    sweep(1'b1, 10);
    // Randomised traffic with mode toggles, stray updates and a mid-run reset.
    am = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) am = 1'($urandom_range(0, 1));
      req  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
      upd  = ($urandom_range(0, 63) == 0);
      sreq = int'($urandom_range(0, 7));
      rst  = (c == 700 || c == 701) ? 1'b0 : 1'b1;
      step(rst, req, am, upd, sreq);
    end
    @(posedge clk);
    #3;
    check("drain", q.size(), 32'd0);
    check("seq_done_pulses", dut_pulses, m_wraps);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
